// File: rtl/load_store_unit.sv
// Load/store unit: bridges datapath load/store requests onto a simple
// req/gnt/rvalid bus with a four-state FSM (IDLE, REQ, WAIT, DONE).
// Optional macro LSU_SUBWORD_EN adds byte/half accesses (lane enables,
// store replication, load lane select with sign/zero extension); without
// it every access is a full word.
module load_store_unit (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i2,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] wdata_i32,
  output logic [31:0] rdata_o32,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o32,
  output logic [3:0]  bus_be_o4,
  output logic [31:0] bus_wdata_o32,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i32
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        req;
  logic        aligned;
  logic        start;
  logic        capture;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_fmt;
  logic [31:0] rdata_q;

  assign req = mem_read_i | mem_write_i;

`ifdef LSU_SUBWORD_EN
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  // Alignment, byte enables and lane-replicated store data from request size
  always_comb begin
    aligned = 1'b1;
    be_d    = '1;
    wdata_d = wdata_i32;
    case (size_i2)
      2'b00: begin
        be_d    = 4'b0001 << addr_i32[1:0];
        wdata_d = {4{wdata_i32[7:0]}};
      end
      2'b01: begin
        aligned = ~addr_i32[0];
        be_d    = 4'b0011 << addr_i32[1:0];
        wdata_d = {2{wdata_i32[15:0]}};
      end
      default: aligned = (addr_i32[1:0] == 2'b00);
    endcase
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    lane_b   = bus_rdata_i32[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? bus_rdata_i32[31:16] : bus_rdata_i32[15:0];
    load_fmt = bus_rdata_i32;
    case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_fmt = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_fmt = bus_rdata_i32;
    endcase
  end

  // Remember access shape for formatting the returned word
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      off_q  <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
    end else if (start) begin
      off_q  <= addr_i32[1:0];
      size_q <= size_i2;
      uns_q  <= unsigned_i;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{size_i2, unsigned_i};
  assign aligned    = (addr_i32[1:0] == 2'b00);
  assign be_d       = '1;
  assign wdata_d    = wdata_i32;
  assign load_fmt   = bus_rdata_i32;
`endif

  assign start   = (state_q == IDLE) & req & aligned;
  // Read data is taken on rvalid in WAIT, or in REQ when it coincides with gnt
  assign capture = bus_rvalid_i & ~bus_we_o &
                   (((state_q == REQ) & bus_gnt_i) | (state_q == WAIT));

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ:  if (bus_gnt_i) state_d = bus_rvalid_i ? DONE : WAIT;
      WAIT: if (bus_rvalid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; stall/misalign are gated by reset so they read 0 while it is held
  always_comb begin
    bus_req_o  = (state_q == REQ);
    stall_o    = reset_ni & (start | (state_q == REQ) | (state_q == WAIT));
    misalign_o = reset_ni & (state_q == IDLE) & req & ~aligned;
    rdata_o32  = rdata_q;
  end

  // Bus request fields registered at acceptance, load result on capture
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bus_we_o      <= 1'b0;
      bus_addr_o32  <= '0;
      bus_be_o4     <= '0;
      bus_wdata_o32 <= '0;
      rdata_q       <= '0;
    end else begin
      if (start) begin
        bus_we_o      <= mem_write_i;
        bus_addr_o32  <= {addr_i32[31:2], 2'b00};
        bus_be_o4     <= be_d;
        bus_wdata_o32 <= wdata_d;
      end
      if (capture) rdata_q <= load_fmt;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports:
- clk_i  in  1  sole clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- mem_read_i  in  1  datapath load request
- mem_write_i  in  1  datapath store request
- size_i2  in  2  00 byte, 01 half, 10/11 word
- unsigned_i  in  1  zero-extend loads when 1
- addr_i32  in  32  byte address (datapath ALU result)
- wdata_i32  in  32  store data (datapath register read port 2)
- rdata_o32  out  32  load result to datapath writeback mux
- stall_o  out  1  hold PC and register write while 1
- misalign_o  out  1  misaligned access flagged, no bus cycle
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 write, 0 read
- bus_addr_o32  out  32  word address, bits [1:0] = 00
- bus_be_o4  out  4  byte enables
- bus_wdata_o32  out  32  lane-replicated store data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  response valid (read data or write acknowledge)
- bus_rdata_i32  in  32  read word

Function
REQ-002 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-003 IDLE: on (mem_read_i|mem_write_i) with an aligned address, SHALL register bus_addr/we/be/wdata, then go to REQ.
REQ-004 Simultaneous mem_read_i and mem_write_i SHALL be treated as a write.
REQ-005 REQ: bus_req_o=1 and all bus outputs SHALL hold stable until bus_gnt_i; on gnt, go to WAIT, or to DONE if bus_rvalid_i is also 1.
REQ-006 WAIT: bus_req_o=0; on bus_rvalid_i, SHALL capture the formatted load data and go to DONE.
REQ-007 DONE: stall_o=0 for exactly one cycle, rdata_o32 SHALL hold the captured value, then return to IDLE unconditionally.
REQ-008 stall_o SHALL equal (IDLE & request & aligned) | REQ | WAIT; it is combinational so the PC holds in the request cycle.
REQ-009 Minimum latency: 3 cycles from request to the DONE (writeback) cycle; 2 stall cycles.
REQ-010 bus_rvalid_i in IDLE/DONE and bus_gnt_i outside REQ SHALL be ignored.
REQ-011 Misaligned request in IDLE: misalign_o=1 combinationally, stall_o=0, no bus cycle, rdata_o32 unchanged, state stays IDLE.
REQ-012 bus_addr_o32 SHALL be {addr_i32[31:2],2'b00}.
REQ-013 rdata_o32 SHALL change only on rvalid capture of a read; write acknowledges SHALL NOT alter it.

Reset
REQ-014 reset_ni low SHALL force: state IDLE, bus_req_o 0, bus_we_o 0, bus_addr_o32 0, bus_be_o4 0, bus_wdata_o32 0, rdata_o32 0, stall_o 0, misalign_o 0.
REQ-015 Reset mid-transaction SHALL abandon the access immediately (bus_req_o drops asynchronously); a later rvalid SHALL be ignored.

Configuration
REQ-016 Macro LSU_SUBWORD_EN defined: byte/half support. bus_be_o4 = 0001<<a[1:0] (byte), 0011<<a[1:0] (half), 1111 (word); store data replicated {4{b}}/{2{h}}; load lane selected by a[1:0] and sign/zero-extended per unsigned_i; misaligned = half with a[0]=1, or word with a[1:0]!=0.
REQ-017 Macro undefined: size_i2 and unsigned_i ignored, every access is a word, bus_be_o4=1111, misaligned = a[1:0]!=0.

Verification
REQ-018 Word load 0x0000_0010, gnt and rvalid in the same cycle as REQ, rdata 0xDEAD_BEEF -> stall_o high 2 cycles, DONE rdata_o32=0xDEAD_BEEF, bus_be_o4=1111.
REQ-019 Store 0x1122_3344 to 0x20, gnt delayed 3 cycles, rvalid 2 cycles later -> bus outputs stable through REQ, stall_o 6 cycles, rdata_o32 unchanged.
REQ-020 (SUBWORD) lb at 0x13, bus word 0x80FF_FFFF -> rdata_o32=0xFFFF_FF80; lbu -> 0x0000_0080; sb 0xAB at 0x13 -> be=1000, wdata=0xABAB_ABAB.
REQ-021 Word load at 0x02 -> misalign_o=1, stall_o=0, bus_req_o never asserted.
REQ-022 Reset pulled low in WAIT, rvalid arriving after release -> state IDLE, rdata_o32=0, no DONE cycle.
